ycr1_imem_arb: RTL and testbench

- Two-requester arbiter that shares one instruction-memory bridge port (memif req/ack/addr/rdata/resp, pipelined, in-order responses) between requester 0 (core fetch) and requester 1 (debug/prefetch).
- Selects one request per cycle and records each accepted request's owner in an order FIFO.
- Routes each returning response to the requester that owns it.

---
 rtl/ycr1_imem_arb_if.sv | 35 +++
 rtl/ycr1_imem_arb.sv | 148 ++++++++++++++
 tb/tb_ycr1_imem_arb.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ycr1_imem_arb_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : ycr1_imem_arb_if                                   |
// | Description : Instruction-memory handshake bundle (req/ack,      |
// |               address, read data, 2-bit response).              |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
interface ycr1_imem_arb_if #(
  parameter int YCR1_ARB_AW = 32
);
  logic                   req;
  logic                   req_ack;
  logic [YCR1_ARB_AW-1:0] addr;
  logic [YCR1_ARB_AW-1:0] rdata;
  logic [1:0]             resp;

  // Requester side: issues requests, receives acks and responses
  modport master (
    output req,
    output addr,
    input  req_ack,
    input  rdata,
    input  resp
  );

  // Memory side: receives requests, returns acks and responses
  modport slave (
    input  req,
    input  addr,
    output req_ack,
    output rdata,
    output resp
  );
endinterface
`default_nettype wire

// File: rtl/ycr1_imem_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : ycr1_imem_arb                                      |
// | Description : Two-requester arbiter sharing one pipelined        |
// |               instruction-memory port. Accepted request owners   |
// |               are queued so in-order responses return to the     |
// |               right requester.                                   |
// | Options     : YCR1_IMEM_ARB_FIXED_PRIO_EN - requester 0 always   |
// |               wins contention (no round-robin pointer).          |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module ycr1_imem_arb #(
  parameter int YCR1_ARB_AW        = 32,
  parameter int YCR1_ARB_ORD_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  ycr1_imem_arb_if.slave  m0,
  ycr1_imem_arb_if.slave  m1,
  ycr1_imem_arb_if.master s,
  output logic            arb_busy,
  output logic            arb_err
);

  localparam int         c_PTR_W       = $clog2(YCR1_ARB_ORD_DEPTH);
  localparam int         c_CNT_W       = $clog2(YCR1_ARB_ORD_DEPTH) + 1;
  localparam logic [1:0] c_RESP_NOTRDY = 2'b00;

  logic [c_CNT_W-1:0]            r_ord_cnt;
  logic [c_PTR_W-1:0]            r_wr_ptr;
  logic [c_PTR_W-1:0]            r_rd_ptr;
  logic [YCR1_ARB_ORD_DEPTH-1:0] r_ord;
  logic                          r_lock;
  logic                          r_lock_id;
  logic                          r_err;
`ifndef YCR1_IMEM_ARB_FIXED_PRIO_EN
  logic                          r_rr_ptr;
`endif

  logic                   w_full;
  logic                   w_lock_hold;
  logic                   w_grant;
  logic                   w_s_req;
  logic                   w_hs;
  logic                   w_resp_vld;
  logic                   w_pop;
  logic                   w_head;
  logic [YCR1_ARB_AW-1:0] w_addr;

  assign w_full      = (r_ord_cnt == c_CNT_W'(YCR1_ARB_ORD_DEPTH));
  // A lock only binds while its owner is still requesting; a dropped
  // request falls back to normal arbitration and the lock clears.
  assign w_lock_hold = r_lock & (r_lock_id ? m1.req : m0.req);

  // Grant selection: held lock, then sole requester, then tie-break
  always_comb begin
    w_grant = 1'b0;
    if (w_lock_hold) begin
      w_grant = r_lock_id;
    end else if (m0.req & ~m1.req) begin
      w_grant = 1'b0;
    end else if (m1.req & ~m0.req) begin
      w_grant = 1'b1;
    end else if (m0.req & m1.req) begin
`ifdef YCR1_IMEM_ARB_FIXED_PRIO_EN
      w_grant = 1'b0;
`else
      w_grant = r_rr_ptr;
`endif
    end
  end

  assign w_s_req    = (m0.req | m1.req) & ~w_full;
  assign w_hs       = w_s_req & s.req_ack;
  assign w_addr     = w_grant ? m1.addr : m0.addr;
  assign s.req      = w_s_req;
  assign s.addr     = w_addr;
  assign m0.req_ack = w_hs & ~w_grant;
  assign m1.req_ack = w_hs &  w_grant;

  assign w_resp_vld = (s.resp != c_RESP_NOTRDY);
  assign w_pop      = w_resp_vld & (r_ord_cnt != '0);
  assign w_head     = r_ord[r_rd_ptr];
  assign m0.resp    = (w_pop & ~w_head) ? s.resp : c_RESP_NOTRDY;
  assign m1.resp    = (w_pop &  w_head) ? s.resp : c_RESP_NOTRDY;
  assign m0.rdata   = s.rdata;
  assign m1.rdata   = s.rdata;
  assign arb_busy   = (r_ord_cnt != '0);
  assign arb_err    = r_err;

  // Order FIFO: push owner on handshake, pop head on each response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ord     <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ord_cnt <= '0;
    end else begin
      if (w_hs) begin
        r_ord[r_wr_ptr] <= w_grant;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_hs, w_pop})
        2'b10:   r_ord_cnt <= r_ord_cnt + 1'b1;
        2'b01:   r_ord_cnt <= r_ord_cnt - 1'b1;
        default: r_ord_cnt <= r_ord_cnt;
      endcase
    end
  end

  // Lock the grant while an offered request waits for the bridge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock    <= 1'b0;
      r_lock_id <= 1'b0;
    end else begin
      r_lock <= w_s_req & ~s.req_ack;
      if (w_s_req & ~s.req_ack) begin
        r_lock_id <= w_grant;
      end
    end
  end

`ifndef YCR1_IMEM_ARB_FIXED_PRIO_EN
  // Round-robin: the requester just served loses the next tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
    end else if (w_hs) begin
      r_rr_ptr <= ~w_grant;
    end
  end
`endif

  // Sticky flag for a response arriving with nothing outstanding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_resp_vld & (r_ord_cnt == '0)) begin
      r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ycr1_imem_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_ycr1_imem_arb                                   |
// | Description : Self-checking bench for ycr1_imem_arb: directed    |
// |               scenarios plus randomized traffic against a        |
// |               queue-based reference model.                       |
// | Options     : YCR1_IMEM_ARB_FIXED_PRIO_EN (mirrors the DUT build) |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_ycr1_imem_arb;

  localparam int AW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic arb_busy;
  logic arb_err;

  always #5 clk = ~clk;

  ycr1_imem_arb_if #(.YCR1_ARB_AW(AW)) m0_if ();
  ycr1_imem_arb_if #(.YCR1_ARB_AW(AW)) m1_if ();
  ycr1_imem_arb_if #(.YCR1_ARB_AW(AW)) s_if ();

  ycr1_imem_arb #(
    .YCR1_ARB_AW        (AW),
    .YCR1_ARB_ORD_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m0       (m0_if),
    .m1       (m1_if),
    .s        (s_if),
    .arb_busy (arb_busy),
    .arb_err  (arb_err)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: queue of owners in acceptance order, tie preference,
  // and the requester whose offer is still waiting on the bridge.
  int q_owner[$];
  int md_pref;
  bit md_wait;
  int md_wait_id;
  bit md_err;

  bit         e_sreq, e_ack0, e_ack1, e_busy, e_err;
  logic [1:0] e_resp0, e_resp1;
  int         e_grant;

  function automatic void model_reset();
    q_owner.delete();
    md_pref    = 0;
    md_wait    = 1'b0;
    md_wait_id = 0;
    md_err     = 1'b0;
  endfunction

  function automatic void model_eval();
    bit r0, r1, full;
    r0   = m0_if.req;
    r1   = m1_if.req;
    full = (q_owner.size() >= DEPTH);
    if (md_wait && ((md_wait_id == 0) ? r0 : r1)) e_grant = md_wait_id;
    else if (r0 && !r1)                          e_grant = 0;
    else if (r1 && !r0)                          e_grant = 1;
`ifdef YCR1_IMEM_ARB_FIXED_PRIO_EN
    else                                         e_grant = 0;
`else
    else if (r0 && r1)                           e_grant = md_pref;
    else                                         e_grant = 0;
`endif
    e_sreq  = (r0 || r1) && !full;
    e_ack0  = e_sreq && s_if.req_ack && (e_grant == 0);
    e_ack1  = e_sreq && s_if.req_ack && (e_grant == 1);
    e_resp0 = 2'b00;
    e_resp1 = 2'b00;
    if (s_if.resp != 2'b00 && q_owner.size() > 0) begin
      if (q_owner[0] == 0) e_resp0 = s_if.resp;
      else                 e_resp1 = s_if.resp;
    end
    e_busy = (q_owner.size() > 0);
    e_err  = md_err;
  endfunction

  function automatic void model_commit();
    if (s_if.resp != 2'b00) begin
      if (q_owner.size() > 0) void'(q_owner.pop_front());
      else                    md_err = 1'b1;
    end
    if (e_sreq && s_if.req_ack) begin
      q_owner.push_back(e_grant);
      md_pref = 1 - e_grant;
    end
    md_wait    = e_sreq && !s_if.req_ack;
    md_wait_id = e_grant;
  endfunction

  task automatic idle();
    m0_if.req     = 1'b0;
    m0_if.addr    = '0;
    m1_if.req     = 1'b0;
    m1_if.addr    = '0;
    s_if.req_ack  = 1'b0;
    s_if.rdata    = '0;
    s_if.resp     = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    idle();
    #1;
    n_vec++; if (s_if.req !== 1'b0)     begin n_miss++; $display("FAIL reset_s_req got %b want 0", s_if.req); end
    n_vec++; if (m0_if.resp !== 2'b00)  begin n_miss++; $display("FAIL reset_m0_resp got %b want 00", m0_if.resp); end
    n_vec++; if (m1_if.resp !== 2'b00)  begin n_miss++; $display("FAIL reset_m1_resp got %b want 00", m1_if.resp); end
    n_vec++; if (arb_busy !== 1'b0)     begin n_miss++; $display("FAIL reset_busy got %b want 0", arb_busy); end
    n_vec++; if (arb_err !== 1'b0)      begin n_miss++; $display("FAIL reset_err got %b want 0", arb_err); end
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    idle();
    m0_if.req = 1'b1; m0_if.addr = 32'h100; s_if.req_ack = 1'b1;
    #1;
    n_vec++; if (s_if.req !== 1'b1)        begin n_miss++; $display("FAIL single_s_req got %b want 1", s_if.req); end
    n_vec++; if (s_if.addr !== 32'h100)    begin n_miss++; $display("FAIL single_s_addr got %h want 00000100", s_if.addr); end
    n_vec++; if (m0_if.req_ack !== 1'b1)   begin n_miss++; $display("FAIL single_m0_ack got %b want 1", m0_if.req_ack); end
    n_vec++; if (m1_if.req_ack !== 1'b0)   begin n_miss++; $display("FAIL single_m1_ack got %b want 0", m1_if.req_ack); end
    @(negedge clk);
    idle();
    #1;
    n_vec++; if (arb_busy !== 1'b1)        begin n_miss++; $display("FAIL single_busy got %b want 1", arb_busy); end
    @(negedge clk);
    s_if.resp = 2'b01; s_if.rdata = 32'hDEADBEEF;
    #1;
    n_vec++; if (m0_if.resp !== 2'b01)        begin n_miss++; $display("FAIL single_m0_resp got %b want 01", m0_if.resp); end
    n_vec++; if (m0_if.rdata !== 32'hDEADBEEF) begin n_miss++; $display("FAIL single_m0_rdata got %h want deadbeef", m0_if.rdata); end
    n_vec++; if (m1_if.resp !== 2'b00)        begin n_miss++; $display("FAIL single_m1_resp got %b want 00", m1_if.resp); end
    @(negedge clk);
    idle();
    #1;
    n_vec++; if (arb_busy !== 1'b0)        begin n_miss++; $display("FAIL single_busy_end got %b want 0", arb_busy); end
  endtask

  task automatic test_alternate();
    int g, p;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      m0_if.req    = (k < 8); m0_if.addr = 32'h1000 + k;
      m1_if.req    = (k < 8); m1_if.addr = 32'h2000 + k;
      s_if.req_ack = 1'b1;
      s_if.resp    = (k > 0) ? 2'b01 : 2'b00;
      s_if.rdata   = k;
`ifdef YCR1_IMEM_ARB_FIXED_PRIO_EN
      g = 0; p = 0;
`else
      g = k % 2; p = (k + 1) % 2;
`endif
      #1;
      if (k < 8) begin
        n_vec++; if (m0_if.req_ack !== 1'(g == 0)) begin n_miss++; $display("FAIL alt_m0_ack cyc %0d got %b want %b", k, m0_if.req_ack, (g == 0)); end
        n_vec++; if (m1_if.req_ack !== 1'(g == 1)) begin n_miss++; $display("FAIL alt_m1_ack cyc %0d got %b want %b", k, m1_if.req_ack, (g == 1)); end
        n_vec++; if (s_if.addr !== ((g == 1) ? 32'h2000 + k : 32'h1000 + k)) begin n_miss++; $display("FAIL alt_s_addr cyc %0d got %h", k, s_if.addr); end
      end
      if (k > 0) begin
        n_vec++; if (m0_if.resp !== ((p == 0) ? 2'b01 : 2'b00)) begin n_miss++; $display("FAIL alt_m0_resp cyc %0d got %b owner %0d", k, m0_if.resp, p); end
        n_vec++; if (m1_if.resp !== ((p == 1) ? 2'b01 : 2'b00)) begin n_miss++; $display("FAIL alt_m1_resp cyc %0d got %b owner %0d", k, m1_if.resp, p); end
      end
    end
  endtask

  task automatic test_lock();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      m1_if.req    = (k < 4); m1_if.addr = 32'h200;
      m0_if.req    = (k >= 1); m0_if.addr = 32'h300;
      s_if.req_ack = (k >= 3);
      s_if.resp    = 2'b00;
      #1;
      if (k < 4) begin
        n_vec++; if (s_if.addr !== 32'h200)              begin n_miss++; $display("FAIL lock_s_addr cyc %0d got %h want 00000200", k, s_if.addr); end
        n_vec++; if (m0_if.req_ack !== 1'b0)             begin n_miss++; $display("FAIL lock_m0_ack cyc %0d got %b want 0", k, m0_if.req_ack); end
        n_vec++; if (m1_if.req_ack !== 1'(k == 3))       begin n_miss++; $display("FAIL lock_m1_ack cyc %0d got %b want %b", k, m1_if.req_ack, (k == 3)); end
      end else begin
        n_vec++; if (m0_if.req_ack !== 1'b1)             begin n_miss++; $display("FAIL lock_m0_after got %b want 1", m0_if.req_ack); end
        n_vec++; if (s_if.addr !== 32'h300)              begin n_miss++; $display("FAIL lock_addr_after got %h want 00000300", s_if.addr); end
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      m0_if.req    = 1'b1; m0_if.addr = 32'h10 * k;
      m1_if.req    = 1'b0;
      s_if.req_ack = 1'b1;
      s_if.resp    = (k == 5) ? 2'b01 : 2'b00;
      #1;
      if (k < 4) begin
        n_vec++; if (m0_if.req_ack !== 1'b1) begin n_miss++; $display("FAIL full_fill_ack cyc %0d got %b want 1", k, m0_if.req_ack); end
      end else if (k < 6) begin
        n_vec++; if (s_if.req !== 1'b0)      begin n_miss++; $display("FAIL full_s_req cyc %0d got %b want 0", k, s_if.req); end
        n_vec++; if (m0_if.req_ack !== 1'b0) begin n_miss++; $display("FAIL full_ack cyc %0d got %b want 0", k, m0_if.req_ack); end
        n_vec++; if (arb_busy !== 1'b1)      begin n_miss++; $display("FAIL full_busy cyc %0d got %b want 1", k, arb_busy); end
        if (k == 5) begin
          n_vec++; if (m0_if.resp !== 2'b01) begin n_miss++; $display("FAIL full_pop_resp got %b want 01", m0_if.resp); end
        end
      end else begin
        n_vec++; if (s_if.req !== 1'b1)      begin n_miss++; $display("FAIL full_resume_s_req got %b want 1", s_if.req); end
        n_vec++; if (m0_if.req_ack !== 1'b1) begin n_miss++; $display("FAIL full_resume_ack got %b want 1", m0_if.req_ack); end
      end
    end
  endtask

  task automatic test_err();
    do_reset();
    @(negedge clk);
    idle();
    s_if.resp = 2'b10;
    #1;
    n_vec++; if (m0_if.resp !== 2'b00) begin n_miss++; $display("FAIL err_m0_resp got %b want 00", m0_if.resp); end
    n_vec++; if (m1_if.resp !== 2'b00) begin n_miss++; $display("FAIL err_m1_resp got %b want 00", m1_if.resp); end
    @(negedge clk);
    idle();
    m0_if.req = 1'b1; s_if.req_ack = 1'b1;
    #1;
    n_vec++; if (arb_err !== 1'b1) begin n_miss++; $display("FAIL err_set got %b want 1", arb_err); end
    @(negedge clk);
    idle();
    s_if.resp = 2'b10;
    #1;
    n_vec++; if (m0_if.resp !== 2'b10) begin n_miss++; $display("FAIL err_route_er got %b want 10", m0_if.resp); end
    @(negedge clk);
    idle();
    #1;
    n_vec++; if (arb_err !== 1'b1) begin n_miss++; $display("FAIL err_sticky got %b want 1", arb_err); end
    // Reset with a request outstanding, then let its response arrive late
    @(negedge clk);
    m0_if.req = 1'b1; s_if.req_ack = 1'b1;
    do_reset();
    @(negedge clk);
    idle();
    #1;
    n_vec++; if (arb_err !== 1'b0) begin n_miss++; $display("FAIL err_cleared got %b want 0", arb_err); end
    n_vec++; if (arb_busy !== 1'b0) begin n_miss++; $display("FAIL err_discard_busy got %b want 0", arb_busy); end
    s_if.resp = 2'b01;
    #1;
    n_vec++; if (m0_if.resp !== 2'b00) begin n_miss++; $display("FAIL err_late_resp got %b want 00", m0_if.resp); end
    @(negedge clk);
    idle();
    #1;
    n_vec++; if (arb_err !== 1'b1) begin n_miss++; $display("FAIL err_late_set got %b want 1", arb_err); end
  endtask

  task automatic test_random();
    bit hold0, hold1;
    hold0 = 1'b0;
    hold1 = 1'b0;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (!hold0) begin m0_if.req = 1'($urandom_range(0, 1)); m0_if.addr = $urandom; end
      if (!hold1) begin m1_if.req = 1'($urandom_range(0, 1)); m1_if.addr = $urandom; end
      s_if.req_ack = ($urandom_range(0, 3) != 0);
      s_if.rdata   = $urandom;
      if (q_owner.size() > 0 && $urandom_range(0, 2) != 0) s_if.resp = 2'($urandom_range(1, 2));
      else                                                 s_if.resp = 2'b00;
      #1;
      model_eval();
      n_vec++; if (s_if.req !== e_sreq)       begin n_miss++; $display("FAIL rnd_s_req cyc %0d got %b want %b", k, s_if.req, e_sreq); end
      if (e_sreq) begin
        n_vec++; if (s_if.addr !== ((e_grant == 1) ? m1_if.addr : m0_if.addr)) begin n_miss++; $display("FAIL rnd_s_addr cyc %0d got %h grant %0d", k, s_if.addr, e_grant); end
      end
      n_vec++; if (m0_if.req_ack !== e_ack0)  begin n_miss++; $display("FAIL rnd_m0_ack cyc %0d got %b want %b", k, m0_if.req_ack, e_ack0); end
      n_vec++; if (m1_if.req_ack !== e_ack1)  begin n_miss++; $display("FAIL rnd_m1_ack cyc %0d got %b want %b", k, m1_if.req_ack, e_ack1); end
      n_vec++; if (m0_if.resp !== e_resp0)    begin n_miss++; $display("FAIL rnd_m0_resp cyc %0d got %b want %b", k, m0_if.resp, e_resp0); end
      n_vec++; if (m1_if.resp !== e_resp1)    begin n_miss++; $display("FAIL rnd_m1_resp cyc %0d got %b want %b", k, m1_if.resp, e_resp1); end
      n_vec++; if (m0_if.rdata !== s_if.rdata) begin n_miss++; $display("FAIL rnd_m0_rdata cyc %0d got %h want %h", k, m0_if.rdata, s_if.rdata); end
      n_vec++; if (m1_if.rdata !== s_if.rdata) begin n_miss++; $display("FAIL rnd_m1_rdata cyc %0d got %h want %h", k, m1_if.rdata, s_if.rdata); end
      n_vec++; if (arb_busy !== e_busy)       begin n_miss++; $display("FAIL rnd_busy cyc %0d got %b want %b", k, arb_busy, e_busy); end
      n_vec++; if (arb_err !== e_err)         begin n_miss++; $display("FAIL rnd_err cyc %0d got %b want %b", k, arb_err, e_err); end
      hold0 = m0_if.req && !e_ack0;
      hold1 = m1_if.req && !e_ack1;
      model_commit();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    test_reset();
    test_single();
    test_alternate();
    test_lock();
    test_full();
    test_err();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
